// File: rtl/pipelined_ram_pkg.sv
// Shared types and default parameters for the pipelined single-port RAM.
package pipelined_ram_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_RD_LAT = 1;
   localparam int unsigned MAX_RD_LAT = 4;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_e;

   function automatic int unsigned be_width(input int unsigned data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/pipelined_ram_if.sv
// Request/response bus between a RAM client (master) and the RAM (slave).
interface pipelined_ram_if
   import pipelined_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);

   localparam int unsigned BE_W = be_width(DATA_W);

   logic              ce;
   logic              we;
   logic [BE_W-1:0]   be;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din;
   logic              clr;
   logic [DATA_W-1:0] dout;
   logic              rvalid;
   logic              ready;

   modport master (
      output ce, we, be, addr, din, clr,
      input  dout, rvalid, ready
   );

   modport slave (
      input  ce, we, be, addr, din, clr,
      output dout, rvalid, ready
   );

endinterface

// File: rtl/pipelined_ram_rd_pipe.sv
// Extra read-latency stages behind the RAM output register; pure wires when RD_LAT=1.
module ram_rd_pipe
   import pipelined_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   localparam int unsigned NSTG = RD_LAT - 1;

   // Chain taps: index 0 is the pipe input, index s+1 is the output of stage s.
   logic [NSTG:0]     v_c;
   logic [DATA_W-1:0] d_c [NSTG+1];

   assign v_c[0] = in_valid;
   assign d_c[0] = in_data;

   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      logic              vld_q;
      logic              vld_d;
      logic [DATA_W-1:0] dat_q;
      logic [DATA_W-1:0] dat_d;

      // Data only advances with a valid token so the tail holds the last read.
      always_comb begin
         vld_d = v_c[s];
         dat_d = dat_q;
         if (v_c[s]) begin
            dat_d = d_c[s];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      assign v_c[s+1] = vld_q;
      assign d_c[s+1] = dat_q;
   end

   if (NSTG == 0) begin : g_no_stages
      logic unused_c;
      assign unused_c = clk ^ rst;
   end

   assign out_valid = v_c[NSTG];
   assign out_data  = d_c[NSTG];

endmodule

// File: rtl/pipelined_ram.sv
// Single-port byte-writable RAM with a self-clearing walk after reset/clr and
// a configurable-latency, fully pipelined read path.
module pipelined_ram
   import pipelined_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic           clk,
   input  logic           rst,
   pipelined_ram_if.slave bus
);

   localparam int unsigned       BE_W      = be_width(DATA_W);
   localparam int unsigned       DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] cnt_d;
   logic              ready_q;
   logic              ready_d;

   logic [BE_W-1:0]   wr_en_c;
   logic [ADDR_W-1:0] wr_addr_c;
   logic [DATA_W-1:0] wr_data_c;
   logic              rd_en_c;

   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;
   logic              rvld_q;
   logic              rvld_d;

   logic [DATA_W-1:0] mem [DEPTH];

   // Control: clear walk owns the write port; user access only in IDLE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_c   = '0;
      wr_addr_c = cnt_q;
      wr_data_c = '0;
      rd_en_c   = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            wr_en_c = '1;
            cnt_d   = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            if (bus.ce && !bus.clr) begin
               if (bus.we) begin
                  wr_en_c   = bus.be;
                  wr_addr_c = bus.addr;
                  wr_data_c = bus.din;
               end else begin
                  rd_en_c = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase

      if (bus.clr) begin
         state_d = ST_CLEAR;
         cnt_d   = '0;
      end

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // Storage is deliberately not reset; zeroing comes from the clear walk.
   always_ff @(posedge clk) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (wr_en_c[b]) begin
            mem[wr_addr_c][8*b +: 8] <= wr_data_c[8*b +: 8];
         end
      end
   end

   always_comb begin
      rvld_d  = rd_en_c;
      rdata_d = rdata_q;
      if (rd_en_c) begin
         rdata_d = mem[bus.addr];
      end
   end

   // First read stage: RAM output register, loaded only on accepted reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvld_q  <= 1'b0;
         rdata_q <= '0;
      end else begin
         rvld_q  <= rvld_d;
         rdata_q <= rdata_d;
      end
   end

   ram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rvld_q),
      .in_data   (rdata_q),
      .out_valid (bus.rvalid),
      .out_data  (bus.dout)
   );

   assign bus.ready = ready_q;

endmodule
